// File: rtl/lcd_bus_receiver.sv
// HD44780-style write-bus responder with a 2x16 DDRAM shadow.
// Ports: clk, reset (async high); bus rs/rw/en/display; read port
// rd_addr -> rd_data (1-cycle); status cursor, busy, entry_inc,
// display_on, err_overrun (sticky).
module lcd_bus_receiver #(
   parameter int CMD_CYCLES   = 4,
   parameter int CLEAR_CYCLES = 40
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rs,
   input  logic       rw,
   input  logic       en,
   input  logic [7:0] display,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_data,
   output logic [4:0] cursor,
   output logic       busy,
   output logic       entry_inc,
   output logic       display_on,
   output logic       err_overrun
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_WAIT,
      S_CLEAR
   } state_t;

   localparam int CW = 16;
   localparam logic [CW-1:0] CMD_LOAD = CW'(CMD_CYCLES - 1);
   localparam logic [CW-1:0] CLR_LOAD = CW'(CLEAR_CYCLES - 33);

   state_t        state;
   logic [4:0]    fill;
   logic [CW-1:0] cnt;
   logic          lat_rs;
   logic [7:0]    lat_d;

   // {en, rs, rw, display} travel together so the bus seen
   // with the en=0 sample is the one that belongs to the strobe.
   logic [10:0] sync1;
   logic [10:0] sync2;
   logic        en_prev;
   logic        strobe;
   logic        s_rs;
   logic        s_rw;
   logic [7:0]  s_d;

   logic [7:0]  mem [32];
   logic        mem_we;
   logic [4:0]  mem_wa;
   logic [7:0]  mem_wd;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1   <= '0;
         sync2   <= '0;
         en_prev <= 1'b0;
      end else begin
         sync1   <= {en, rs, rw, display};
         sync2   <= sync1;
         en_prev <= sync2[10];
      end
   end

   assign strobe = en_prev & ~sync2[10];
   assign s_rs   = sync2[9];
   assign s_rw   = sync2[8];
   assign s_d    = sync2[7:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_CLEAR;
         fill        <= '0;
         cnt         <= '0;
         busy        <= 1'b1;
         cursor      <= '0;
         entry_inc   <= 1'b1;
         display_on  <= 1'b0;
         err_overrun <= 1'b0;
         lat_rs      <= 1'b0;
         lat_d       <= '0;
      end else begin
         // Reads are ignored outright; writes while busy are lost.
         if (strobe && !s_rw && state != S_IDLE)
            err_overrun <= 1'b1;
         unique case (state)
            S_IDLE: begin
               if (strobe && !s_rw) begin
                  lat_rs <= s_rs;
                  lat_d  <= s_d;
                  state  <= S_EXEC;
                  busy   <= 1'b1;
               end
            end
            S_EXEC: begin
               state <= S_WAIT;
               cnt   <= CMD_LOAD;
               if (lat_rs) begin
                  cursor <= entry_inc ? cursor + 5'd1
                                      : cursor - 5'd1;
               end else begin
                  unique casez (lat_d)
                     8'b1???????:
                        cursor <= {lat_d[6], lat_d[3:0]};
                     8'b01??????: begin end
                     8'b001?????: begin end
                     8'b0001????: begin end
                     8'b00001???:
                        display_on <= lat_d[2];
                     8'b000001??:
                        entry_inc <= lat_d[1];
                     8'b0000001?:
                        cursor <= '0;
                     8'b00000001: begin
                        cursor    <= '0;
                        entry_inc <= 1'b1;
                        fill      <= '0;
                        state     <= S_CLEAR;
                     end
                     default: begin end
                  endcase
               end
            end
            S_CLEAR: begin
               fill <= fill + 5'd1;
               if (fill == 5'd31) begin
                  state <= S_WAIT;
                  cnt   <= CLR_LOAD;
               end
            end
            S_WAIT: begin
               if (cnt == '0) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // The shadow needs no reset: the fill rewrites every entry.
   assign mem_we = (state == S_CLEAR) ||
                   (state == S_EXEC && lat_rs);
   assign mem_wa = (state == S_CLEAR) ? fill : cursor;
   assign mem_wd = (state == S_CLEAR) ? 8'h20 : lat_d;

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_wa] <= mem_wd;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rd_data <= '0;
      else
         rd_data <= mem[rd_addr];
   end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Self-checking bench for lcd_bus_receiver: table of bus writes
// with expected state, plus overrun and reset-during-clear sequences.
module tb_lcd_bus_receiver;

   localparam int CMD_CYCLES   = 4;
   localparam int CLEAR_CYCLES = 40;
   localparam int NV           = 19;

   logic       clk = 1'b0;
   logic       reset;
   logic       rs;
   logic       rw;
   logic       en;
   logic [7:0] display;
   logic [4:0] rd_addr;
   logic [7:0] rd_data;
   logic [4:0] cursor;
   logic       busy;
   logic       entry_inc;
   logic       display_on;
   logic       err_overrun;

   typedef struct {
      logic       rs;
      logic       rw;
      logic [7:0] d;
      logic       chk;
      logic [4:0] addr;
      logic [7:0] data;
      logic [4:0] cur;
      logic       don;
      logic       einc;
   } vec_t;

   vec_t       vecs [NV];
   vec_t       exp_q [$];
   vec_t       e;
   logic [7:0] exp_mem [32];
   logic [7:0] d;
   int         n;
   int         checks = 0;
   int         passes = 0;

   always #5 clk = ~clk;

   lcd_bus_receiver #(
      .CMD_CYCLES  (CMD_CYCLES),
      .CLEAR_CYCLES(CLEAR_CYCLES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rs         (rs),
      .rw         (rw),
      .en         (en),
      .display    (display),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .cursor     (cursor),
      .busy       (busy),
      .entry_inc  (entry_inc),
      .display_on (display_on),
      .err_overrun(err_overrun)
   );

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act === exp)
         passes++;
      else
         $display("FAIL %s: got 0x%0h, want 0x%0h",
                  name, act, exp);
   endtask

   task automatic read_mem(input logic [4:0] a,
                           output logic [7:0] v);
      @(negedge clk);
      rd_addr = a;
      @(posedge clk);
      #1;
      v = rd_data;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (busy) begin
         checks++;
         $display("FAIL idle_timeout: busy=1 after %0d cycles", k);
      end
   endtask

   task automatic pulse(input logic r, input logic w,
                        input logic [7:0] v);
      @(negedge clk);
      rs      = r;
      rw      = w;
      display = v;
      en      = 1'b1;
      repeat (3) @(negedge clk);
      en = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic write_bus(input logic r, input logic w,
                            input logic [7:0] v);
      pulse(r, w, v);
      wait_idle();
   endtask

   task automatic count_clear(input string name);
      int k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (busy && k < 200);
      chk(name, k, CLEAR_CYCLES);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_cursor"}, cursor, 0);
      chk({tag, "_einc"}, entry_inc, 1);
      chk({tag, "_don"}, display_on, 0);
      chk({tag, "_err"}, err_overrun, 0);
      chk({tag, "_rd"}, rd_data, 0);
   endtask

   task automatic dump_all(input string name);
      for (int i = 0; i < 32; i++) begin
         read_mem(5'(i), d);
         chk($sformatf("%s_%0d", name, i), d, exp_mem[i]);
      end
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 8'h41, 1'b1, 5'd0,  8'h41, 5'd1,  1'b0, 1'b1};
      vecs[1]  = '{1'b1, 1'b0, 8'h42, 1'b1, 5'd1,  8'h42, 5'd2,  1'b0, 1'b1};
      vecs[2]  = '{1'b0, 1'b0, 8'hC5, 1'b0, 5'd0,  8'h00, 5'd21, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 1'b0, 8'h5A, 1'b1, 5'd21, 8'h5A, 5'd22, 1'b0, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 8'h0C, 1'b0, 5'd0,  8'h00, 5'd22, 1'b1, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, 8'h04, 1'b0, 5'd0,  8'h00, 5'd22, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 8'h80, 1'b0, 5'd0,  8'h00, 5'd0,  1'b1, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 8'h31, 1'b1, 5'd0,  8'h31, 5'd31, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 8'h32, 1'b1, 5'd31, 8'h32, 5'd30, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 8'hB7, 1'b0, 5'd0,  8'h00, 5'd7,  1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 8'h06, 1'b0, 5'd0,  8'h00, 5'd7,  1'b1, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 8'h7F, 1'b0, 5'd0,  8'h00, 5'd7,  1'b1, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 8'h3F, 1'b0, 5'd0,  8'h00, 5'd7,  1'b1, 1'b1};
      vecs[13] = '{1'b0, 1'b0, 8'h08, 1'b0, 5'd0,  8'h00, 5'd7,  1'b0, 1'b1};
      vecs[14] = '{1'b0, 1'b0, 8'h03, 1'b0, 5'd0,  8'h00, 5'd0,  1'b0, 1'b1};
      vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0,  8'h00, 5'd0,  1'b0, 1'b1};
      vecs[16] = '{1'b0, 1'b0, 8'hDF, 1'b0, 5'd0,  8'h00, 5'd31, 1'b0, 1'b1};
      vecs[17] = '{1'b1, 1'b0, 8'h55, 1'b1, 5'd31, 8'h55, 5'd0,  1'b0, 1'b1};
      vecs[18] = '{1'b1, 1'b1, 8'h99, 1'b1, 5'd0,  8'h31, 5'd0,  1'b0, 1'b1};

      reset   = 1'b1;
      en      = 1'b0;
      rs      = 1'b0;
      rw      = 1'b0;
      display = 8'h00;
      rd_addr = 5'd0;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");

      reset = 1'b0;
      count_clear("rst_clear_busy");
      for (int i = 0; i < 32; i++)
         exp_mem[i] = 8'h20;
      dump_all("fill");
      chk("fill_cursor", cursor, 0);
      chk("fill_err", err_overrun, 0);

      for (int i = 0; i < NV; i++) begin
         exp_q.push_back(vecs[i]);
         write_bus(vecs[i].rs, vecs[i].rw, vecs[i].d);
         e = exp_q.pop_front();
         chk($sformatf("v%0d_cursor", i), cursor, e.cur);
         chk($sformatf("v%0d_don", i), display_on, e.don);
         chk($sformatf("v%0d_einc", i), entry_inc, e.einc);
         chk($sformatf("v%0d_err", i), err_overrun, 0);
         if (e.chk) begin
            exp_mem[e.addr] = e.data;
            read_mem(e.addr, d);
            chk($sformatf("v%0d_mem", i), d, e.data);
         end
      end
      dump_all("table_mem");

      // Second strobe lands while the first is still executing.
      @(negedge clk);
      rs      = 1'b1;
      rw      = 1'b0;
      display = 8'h61;
      en      = 1'b1;
      repeat (3) @(negedge clk);
      en = 1'b0;
      n  = 0;
      while (!busy && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("ovr_accept_busy", busy, 1);
      @(negedge clk);
      display = 8'h62;
      en      = 1'b1;
      @(negedge clk);
      en = 1'b0;
      repeat (4) @(negedge clk);
      wait_idle();
      exp_mem[0] = 8'h61;
      chk("ovr_err", err_overrun, 1);
      chk("ovr_cursor", cursor, 1);
      read_mem(5'd0, d);
      chk("ovr_mem0", d, 8'h61);
      read_mem(5'd1, d);
      chk("ovr_mem1", d, 8'h42);
      write_bus(1'b1, 1'b0, 8'h63);
      exp_mem[1] = 8'h63;
      chk("ovr_sticky", err_overrun, 1);
      chk("ovr_cursor2", cursor, 2);
      dump_all("ovr_mem");

      // Reset arriving part-way through a commanded clear.
      write_bus(1'b0, 1'b0, 8'h0C);
      chk("pre_don", display_on, 1);
      write_bus(1'b1, 1'b0, 8'h77);
      chk("pre_cursor", cursor, 3);
      pulse(1'b0, 1'b0, 8'h01);
      repeat (9) @(negedge clk);
      chk("clr_busy", busy, 1);
      reset = 1'b1;
      #1;
      chk_reset_vals("midrst");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      count_clear("midrst_clear_busy");
      for (int i = 0; i < 32; i++)
         exp_mem[i] = 8'h20;
      dump_all("refill");
      chk("refill_cursor", cursor, 0);
      chk("refill_don", display_on, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
